// File: rtl/tbuf_pkg.sv
// Shared types and address helpers for the ping-pong block transposer.
// The address layout {bank, row, col} is composed in one place so writer and reader cannot disagree.
`timescale 1ns/1ps
package tbuf_pkg;

    typedef enum logic {
        MODE_PASS  = 1'b0,
        MODE_TRANS = 1'b1
    } mode_e;

    // Widest address for N=32: 1 bank bit + 5 row bits + 5 col bits.
    localparam int ADDR_W_MAX = 11;

    function automatic int tbuf_addr_w(input int n);
        return 2 * $clog2(n) + 1;
    endfunction

    function automatic logic [ADDR_W_MAX-1:0] tbuf_addr(
        input logic       bank,
        input logic [4:0] row,
        input logic [4:0] col,
        input int         log2n
    );
        logic [ADDR_W_MAX-1:0] a;
        a = (ADDR_W_MAX'(bank) << (2 * log2n))
          | (ADDR_W_MAX'(row) << log2n)
          | ADDR_W_MAX'(col);
        return a;
    endfunction

endpackage

// File: rtl/tbuf_ram.sv
// Simple dual-port RAM: one write port, one registered read port with one cycle of latency.
// No reset; contents are only meaningful once written.
`timescale 1ns/1ps
module tbuf_ram #(
    parameter int DATA_W = 12,
    parameter int ADDR_W = 7
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [0:(1 << ADDR_W)-1];
    logic [DATA_W-1:0] r_q;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_q <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_q;

endmodule

// File: rtl/transpose_buffer_hs.sv
// Ping-pong N x N block transposer: one bank fills row-major while the other drains
// either column-major (transpose) or row-major (pass-through) into a 2-entry skid FIFO.
`timescale 1ns/1ps
module transpose_buffer_hs
    import tbuf_pkg::*;
#(
    parameter int DATA_W = 12,
    parameter int N      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_first,
    output logic              out_last
);

    localparam int LOG2N = $clog2(N);
    localparam int CNT_W = 2 * LOG2N;
    localparam int ADDR_W = tbuf_addr_w(N);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N * N - 1);

    // A transfer happens on a rising edge where valid & ready are both high; valid never
    // waits on ready, and the payload must stay stable while valid is high and ready is low.

    logic [1:0]        r_full;
    mode_e             r_mode [2];
    logic              r_wbank;
    logic [CNT_W-1:0]  r_wcnt;
    logic              r_rbank;
    logic [CNT_W-1:0]  r_rcnt;
    logic              r_rd_vld;
    logic              r_rd_first;
    logic              r_rd_last;
    logic [DATA_W-1:0] r_fifo_data [2];
    logic [1:0]        r_fifo_first;
    logic [1:0]        r_fifo_last;
    logic              r_fifo_wptr;
    logic              r_fifo_rptr;
    logic [1:0]        r_fifo_cnt;

    logic              w_wr_en;
    logic              w_wr_last;
    logic              w_rd_en;
    logic              w_rd_last;
    logic              w_pop;
    logic              w_trans;
    logic [2:0]        w_occ_next;
    logic [LOG2N-1:0]  w_rrow;
    logic [LOG2N-1:0]  w_rcol;
    logic [ADDR_W-1:0] w_waddr;
    logic [ADDR_W-1:0] w_raddr;
    logic [DATA_W-1:0] w_rdata;

    assign in_ready  = ~rst & ~r_full[r_wbank];
    assign w_wr_en   = in_valid & in_ready;
    assign w_wr_last = w_wr_en & (r_wcnt == CNT_LAST);

    assign out_valid = (r_fifo_cnt != 2'd0);
    assign w_pop     = out_valid & out_ready;

    // A read may only issue if its data is guaranteed a FIFO slot when it lands.
    assign w_occ_next = 3'(r_fifo_cnt) + 3'(r_rd_vld) - 3'(w_pop);
    assign w_rd_en    = r_full[r_rbank] & (w_occ_next < 3'd2);
    assign w_rd_last  = w_rd_en & (r_rcnt == CNT_LAST);

    assign w_trans = (r_mode[r_rbank] == MODE_TRANS);
    assign w_rrow  = w_trans ? r_rcnt[LOG2N-1:0] : r_rcnt[CNT_W-1:LOG2N];
    assign w_rcol  = w_trans ? r_rcnt[CNT_W-1:LOG2N] : r_rcnt[LOG2N-1:0];

    assign w_waddr = ADDR_W'(tbuf_addr(r_wbank, 5'(r_wcnt[CNT_W-1:LOG2N]),
                                       5'(r_wcnt[LOG2N-1:0]), LOG2N));
    assign w_raddr = ADDR_W'(tbuf_addr(r_rbank, 5'(w_rrow), 5'(w_rcol), LOG2N));

    tbuf_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .i_clk   (clk),
        .i_we    (w_wr_en),
        .i_waddr (w_waddr),
        .i_wdata (in_data),
        .i_re    (w_rd_en),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

    // Writer and reader only ever touch opposite banks, so set and clear never collide.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_full    <= 2'b00;
            r_mode[0] <= MODE_PASS;
            r_mode[1] <= MODE_PASS;
            r_wbank   <= 1'b0;
            r_wcnt    <= '0;
            r_rbank   <= 1'b0;
            r_rcnt    <= '0;
        end else begin
            if (w_wr_en) begin
                if (r_wcnt == '0) begin
                    r_mode[r_wbank] <= mode_e'(in_mode);
                end
                r_wcnt <= r_wcnt + CNT_W'(1);
                if (w_wr_last) begin
                    r_full[r_wbank] <= 1'b1;
                    r_wbank         <= ~r_wbank;
                end
            end
            if (w_rd_en) begin
                r_rcnt <= r_rcnt + CNT_W'(1);
                if (w_rd_last) begin
                    r_full[r_rbank] <= 1'b0;
                    r_rbank         <= ~r_rbank;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_vld   <= 1'b0;
            r_rd_first <= 1'b0;
            r_rd_last  <= 1'b0;
        end else begin
            r_rd_vld   <= w_rd_en;
            r_rd_first <= w_rd_en & (r_rcnt == '0);
            r_rd_last  <= w_rd_last;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                r_fifo_data[i] <= '0;
            end
            r_fifo_first <= 2'b00;
            r_fifo_last  <= 2'b00;
            r_fifo_wptr  <= 1'b0;
            r_fifo_rptr  <= 1'b0;
            r_fifo_cnt   <= 2'd0;
        end else begin
            if (r_rd_vld) begin
                r_fifo_data[r_fifo_wptr]  <= w_rdata;
                r_fifo_first[r_fifo_wptr] <= r_rd_first;
                r_fifo_last[r_fifo_wptr]  <= r_rd_last;
                r_fifo_wptr               <= ~r_fifo_wptr;
            end
            if (w_pop) begin
                r_fifo_rptr <= ~r_fifo_rptr;
            end
            r_fifo_cnt <= r_fifo_cnt + 2'(r_rd_vld) - 2'(w_pop);
        end
    end

    assign out_data  = r_fifo_data[r_fifo_rptr];
    assign out_first = r_fifo_first[r_fifo_rptr];
    assign out_last  = r_fifo_last[r_fifo_rptr];

endmodule

// File: tb/tb_transpose_buffer_hs.sv
// Bench for transpose_buffer_hs: N=8 main instance plus an N=4/8-bit instance for pass-through.
// Expected output is derived from the block contents and mode by index arithmetic.
`timescale 1ns/1ps
module tb_transpose_buffer_hs;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid, in_ready, in_mode;
    logic [11:0] in_data;
    logic        out_valid, out_ready, out_first, out_last;
    logic [11:0] out_data;
    logic        in_valid4, in_ready4, in_mode4;
    logic [7:0]  in_data4;
    logic        out_valid4, out_ready4, out_first4, out_last4;
    logic [7:0]  out_data4;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int ready_mode = 0;
    int stall_cnt = 0;
    int acc_cnt = 0;
    int last_acc_cyc = 0;
    int hs_cnt = 0;
    int hs_first_cyc = 0;
    int hs_last_cyc = 0;

    logic [13:0] exp_q [$];
    logic [11:0] out_log [$];

    typedef struct {
        logic        mode;
        logic [11:0] base;
        int          idx;
        logic [11:0] exp;
    } vec_t;
    vec_t vecs [8];

    transpose_buffer_hs u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_first (out_first),
        .out_last  (out_last)
    );

    transpose_buffer_hs #(.DATA_W(8), .N(4)) u_dut4 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid4),
        .in_ready  (in_ready4),
        .in_data   (in_data4),
        .in_mode   (in_mode4),
        .out_valid (out_valid4),
        .out_ready (out_ready4),
        .out_data  (out_data4),
        .out_first (out_first4),
        .out_last  (out_last4)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Drive one block (or a partial one); a full block pushes its expected output stream.
    task automatic send_block(input int n_samp, input logic [11:0] base, input bit rnd,
                              input logic mode0, input int toggle_at);
        logic [11:0] blk [64];
        int          wait_cnt;
        int          idx;
        for (int i = 0; i < n_samp; i++) begin
            blk[i]   = rnd ? 12'($urandom) : base + 12'(i);
            in_valid = 1'b1;
            in_data  = blk[i];
            in_mode  = (i >= toggle_at) ? ~mode0 : mode0;
            wait_cnt = 0;
            @(negedge clk);
            while (!in_ready && wait_cnt < 1000) begin
                stall_cnt++;
                wait_cnt++;
                @(negedge clk);
            end
            if (!in_ready) begin
                n_checks++;
                n_fail++;
                $display("FAIL in_accept_timeout: sample %0d never accepted, expected acceptance", i);
                in_valid = 1'b0;
                return;
            end
            acc_cnt++;
            last_acc_cyc = cyc;
            sync();
        end
        if (n_samp == 64) begin
            for (int k = 0; k < 64; k++) begin
                idx = mode0 ? (k % 8) * 8 + k / 8 : k;
                exp_q.push_back({k == 0, k == 63, blk[idx]});
            end
        end
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check({name, "_drain_left"}, 32'(exp_q.size()), 32'd0);
        repeat (4) @(negedge clk);
        check({name, "_idle"}, 32'(out_valid), 32'd0);
        sync();
    endtask

    // out_ready driver: 0 = held high, 1 = held low, 2 = random 50%
    initial begin
        out_ready  = 1'b1;
        out_ready4 = 1'b1;
        forever begin
            sync();
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'b0;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Scoreboard: order, flags, and stability while stalled
    initial begin
        logic [13:0] held;
        logic [13:0] got;
        logic [13:0] want;
        logic        prev_stall;
        prev_stall = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                got = {out_first, out_last, out_data};
                if (prev_stall) begin
                    check("stall_valid", 32'(out_valid), 32'd1);
                    check("stall_hold", 32'(got), 32'(held));
                end
                if (out_valid && out_ready) begin
                    out_log.push_back(out_data);
                    if (hs_cnt == 0) hs_first_cyc = cyc;
                    hs_last_cyc = cyc;
                    hs_cnt++;
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_out: got 0x%0h, expected no output", got);
                    end else begin
                        want = exp_q.pop_front();
                        check("out_sample", 32'(got), 32'(want));
                    end
                end
                prev_stall = out_valid && !out_ready;
                held = got;
            end
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        int n;
        int got4;
        int acc_base;
        logic [31:0] act;

        in_valid = 0; in_data = '0; in_mode = 0;
        in_valid4 = 0; in_data4 = '0; in_mode4 = 0;

        vecs[0] = '{1'b1, 12'd0,   0,  12'd0};
        vecs[1] = '{1'b1, 12'd0,   1,  12'd8};
        vecs[2] = '{1'b1, 12'd0,   7,  12'd56};
        vecs[3] = '{1'b1, 12'd0,   8,  12'd1};
        vecs[4] = '{1'b1, 12'd0,   10, 12'd17};
        vecs[5] = '{1'b1, 12'd0,   63, 12'd63};
        vecs[6] = '{1'b0, 12'd0,   9,  12'd9};
        vecs[7] = '{1'b1, 12'd100, 1,  12'd108};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_first", 32'(out_first), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_out_valid4", 32'(out_valid4), 32'd0);
        sync();
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        check("post_rst_out_valid", 32'(out_valid), 32'd0);
        sync();

        // N=4 pass-through on the second instance
        for (int i = 0; i < 16; i++) begin
            in_valid4 = 1'b1;
            in_data4  = 8'(i);
            in_mode4  = 1'b0;
            n = 0;
            @(negedge clk);
            while (!in_ready4 && n < 100) begin
                n++;
                @(negedge clk);
            end
            check("p4_accept", 32'(in_ready4), 32'd1);
            sync();
        end
        in_valid4 = 1'b0;
        got4 = 0;
        for (int c = 0; c < 60 && got4 < 16; c++) begin
            @(negedge clk);
            if (out_valid4 && out_ready4) begin
                check("p4_data", 32'(out_data4), 32'(got4));
                check("p4_first", 32'(out_first4), 32'(got4 == 0));
                check("p4_last", 32'(out_last4), 32'(got4 == 15));
                got4++;
            end
        end
        check("p4_count", 32'(got4), 32'd16);
        sync();

        // Transpose of 0..63 with first-output latency
        out_log.delete();
        send_block(64, 12'd0, 1'b0, 1'b1, 64);
        in_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 20) begin
            n++;
            @(negedge clk);
        end
        check("first_out_latency", 32'(cyc - last_acc_cyc), 32'd3);
        wait_drain("trans0");
        check("trans0_count", 32'(out_log.size()), 32'd64);

        // Table of probe points into single blocks
        for (int v = 0; v < 8; v++) begin
            out_log.delete();
            send_block(64, vecs[v].base, 1'b0, vecs[v].mode, 64);
            in_valid = 1'b0;
            wait_drain("vec");
            act = (out_log.size() > vecs[v].idx) ? 32'(out_log[vecs[v].idx]) : 32'hdead_beef;
            check($sformatf("vec%0d_sample%0d", v, vecs[v].idx), act, 32'(vecs[v].exp));
        end

        // Streaming: four back-to-back transpose blocks
        stall_cnt = 0;
        hs_cnt = 0;
        for (int b = 0; b < 4; b++) begin
            send_block(64, 12'd0, 1'b1, 1'b1, 64);
        end
        in_valid = 1'b0;
        check("stream_in_stalls", 32'(stall_cnt), 32'd0);
        wait_drain("stream");
        check("stream_out_count", 32'(hs_cnt), 32'd256);
        check("stream_out_span", 32'(hs_last_cyc - hs_first_cyc), 32'd255);

        // Back-pressure: 3 blocks offered against a stalled output
        ready_mode = 1;
        sync();
        sync();
        acc_base = acc_cnt;
        fork
            begin
                for (int b = 0; b < 3; b++) begin
                    send_block(64, 12'd0, 1'b1, 1'(b % 2 == 0), 64);
                end
                in_valid = 1'b0;
            end
            begin
                repeat (200) @(negedge clk);
                check("bp_accepts", 32'(acc_cnt - acc_base), 32'd128);
                check("bp_in_ready_low", 32'(in_ready), 32'd0);
                ready_mode = 2;
            end
        join
        wait_drain("bp");
        ready_mode = 0;
        sync();

        // Mode mix: in_mode flips mid-block A, block B is pass-through
        send_block(64, 12'd0, 1'b1, 1'b1, 5);
        send_block(64, 12'd0, 1'b1, 1'b0, 64);
        in_valid = 1'b0;
        wait_drain("modemix");

        // Reset with one stored block and a partial block in flight
        ready_mode = 1;
        sync();
        sync();
        send_block(64, 12'd0, 1'b1, 1'b1, 64);
        send_block(30, 12'd0, 1'b1, 1'b1, 64);
        in_valid = 1'b0;
        rst = 1'b1;
        exp_q.delete();
        ready_mode = 0;
        sync();
        rst = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        sync();
        out_log.delete();
        send_block(64, 12'd100, 1'b0, 1'b1, 64);
        in_valid = 1'b0;
        wait_drain("post_reset");
        check("post_reset_count", 32'(out_log.size()), 32'd64);
        act = (out_log.size() > 1) ? 32'(out_log[1]) : 32'hdead_beef;
        check("post_reset_sample1", act, 32'd108);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
